// File: rtl/fetch_group_queue_if.sv
// Fetch-to-decode group transfer bundle: push side from fetch, pop side to decode.
// The queue uses the slave modport; the fetch/decode side uses master.
interface fetch_group_queue_if #(
    parameter int unsigned FETCH_WIDTH    = 2,
    parameter int unsigned ENTRY_NUM      = 6,
    parameter int unsigned INSN_BIT_WIDTH = 32,
    parameter int unsigned PC_BIT_WIDTH   = 32
);
    localparam int unsigned CNT_W = $clog2(ENTRY_NUM + 1);

    logic                                   push_valid;
    logic                                   push_ready;
    logic [FETCH_WIDTH-1:0]                 push_slot_valid;
    logic [FETCH_WIDTH*INSN_BIT_WIDTH-1:0]  push_insn;
    logic [FETCH_WIDTH*PC_BIT_WIDTH-1:0]    push_pc;

    logic                                   pop_valid;
    logic                                   pop_ready;
    logic [FETCH_WIDTH-1:0]                 pop_slot_valid;
    logic [FETCH_WIDTH*INSN_BIT_WIDTH-1:0]  pop_insn;
    logic [FETCH_WIDTH*PC_BIT_WIDTH-1:0]    pop_pc;

    logic [CNT_W-1:0]                       count;

    modport slave (
        input  push_valid, push_slot_valid, push_insn, push_pc, pop_ready,
        output push_ready, pop_valid, pop_slot_valid, pop_insn, pop_pc, count
    );

    modport master (
        output push_valid, push_slot_valid, push_insn, push_pc, pop_ready,
        input  push_ready, pop_valid, pop_slot_valid, pop_insn, pop_pc, count
    );
endinterface

// File: rtl/fetch_group_queue.sv
// Decoupling FIFO of whole fetch groups between I-cache fetch and decode.
// Non-power-of-two depth; single-cycle flush; pop data is a direct read of the head entry.
module fetch_group_queue #(
    parameter int unsigned FETCH_WIDTH    = 2,
    parameter int unsigned ENTRY_NUM      = 6,
    parameter int unsigned INSN_BIT_WIDTH = 32,
    parameter int unsigned PC_BIT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fetch_group_queue_if.slave    bus
);
    localparam int unsigned PTR_W      = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam int unsigned CNT_W      = $clog2(ENTRY_NUM + 1);
    localparam int unsigned INSN_GRP_W = FETCH_WIDTH * INSN_BIT_WIDTH;
    localparam int unsigned PC_GRP_W   = FETCH_WIDTH * PC_BIT_WIDTH;

    logic [FETCH_WIDTH-1:0] slot_valid_mem [ENTRY_NUM];
    logic [INSN_GRP_W-1:0]  insn_mem       [ENTRY_NUM];
    logic [PC_GRP_W-1:0]    pc_mem         [ENTRY_NUM];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;

    logic full;
    logic empty;
    logic push_fire;
    logic pop_fire;

    // Wrap by compare-and-clear so any depth works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ENTRY_NUM - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake qualification uses registered occupancy only.
    always_comb begin
        full      = (count_q == CNT_W'(ENTRY_NUM));
        empty     = (count_q == '0);
        push_fire = bus.push_valid & ~full  & ~flush;
        pop_fire  = bus.pop_ready  & ~empty & ~flush;
    end

    always_comb begin
        count_next = count_q;
        if (push_fire && !pop_fire) begin
            count_next = count_q + CNT_W'(1);
        end else if (pop_fire && !push_fire) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) begin
                tail <= ptr_inc(tail);
            end
            if (pop_fire) begin
                head <= ptr_inc(head);
            end
            count_q <= count_next;
        end
    end

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push_fire) begin
            slot_valid_mem[tail] <= bus.push_slot_valid;
            insn_mem[tail]       <= bus.push_insn;
            pc_mem[tail]         <= bus.push_pc;
        end
    end

    assign bus.push_ready     = ~full;
    assign bus.pop_valid      = ~empty;
    assign bus.pop_slot_valid = empty ? '0 : slot_valid_mem[head];
    assign bus.pop_insn       = insn_mem[head];
    assign bus.pop_pc         = pc_mem[head];
    assign bus.count          = count_q;

`ifndef SYNTHESIS
    // A stalled producer must hold its group until it is taken.
    a_push_hold: assert property (@(posedge clk) disable iff (rst || flush)
        (bus.push_valid && full) |=>
            (!bus.push_valid || ($stable(bus.push_slot_valid) &&
                                 $stable(bus.push_insn) && $stable(bus.push_pc))));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(ENTRY_NUM));
`endif
endmodule

// File: tb/tb_fetch_group_queue.sv
// Scoreboard bench for fetch_group_queue: stimulus pushes expected groups,
// a negedge monitor pops and compares whenever decode takes the head group.
module tb_fetch_group_queue;
    localparam int unsigned FW = 2;
    localparam int unsigned EN = 6;
    localparam int unsigned IW = 32;
    localparam int unsigned PW = 32;

    typedef struct packed {
        logic [FW-1:0]    sv;
        logic [FW*IW-1:0] insn;
        logic [FW*PW-1:0] pc;
    } grp_t;

    logic clk;
    logic rst;
    logic flush;

    fetch_group_queue_if #(.FETCH_WIDTH(FW), .ENTRY_NUM(EN),
                           .INSN_BIT_WIDTH(IW), .PC_BIT_WIDTH(PW)) bus ();

    fetch_group_queue #(.FETCH_WIDTH(FW), .ENTRY_NUM(EN),
                        .INSN_BIT_WIDTH(IW), .PC_BIT_WIDTH(PW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    grp_t exp_q[$];
    grp_t cur;
    int   mcount;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic grp_t mk(input logic [FW-1:0] sv, input logic [31:0] pc0);
        grp_t g;
        g.sv   = sv;
        g.pc   = {pc0 + 32'd4, pc0};
        g.insn = {(pc0 + 32'd4) ^ 32'hA500_0013, pc0 ^ 32'hA500_0013};
        return g;
    endfunction

    task automatic drive(input logic pv, input grp_t g, input logic pr);
        cur                 = g;
        bus.push_valid      = pv;
        bus.push_slot_valid = g.sv;
        bus.push_insn       = g.insn;
        bus.push_pc         = g.pc;
        bus.pop_ready       = pr;
    endtask

    // One clock; the reference occupancy/contents follow the driven inputs.
    task automatic cycle();
        logic pf;
        logic pp;
        @(posedge clk);
        pf = bus.push_valid && (mcount != EN) && !flush && !rst;
        pp = bus.pop_ready && (mcount != 0) && !flush && !rst;
        if (rst || flush) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            if (pf) exp_q.push_back(cur);
            mcount = mcount + int'(pf) - int'(pp);
        end
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"},      64'(bus.count),      64'(mcount));
        chk({tag, "_pop_valid"},  64'(bus.pop_valid),  64'(mcount != 0));
        chk({tag, "_push_ready"}, 64'(bus.push_ready), 64'(mcount != EN));
    endtask

    // Monitor: compare every group decode actually consumes.
    always @(negedge clk) begin
        grp_t e;
        if (!rst && !flush && bus.pop_ready) begin
            chk("mon_pop_valid", 64'(bus.pop_valid), 64'(mcount != 0));
            if (bus.pop_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %0h required no group", bus.pop_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_slot_valid", 64'(bus.pop_slot_valid), 64'(e.sv));
                    chk("pop_insn",       64'(bus.pop_insn),       64'(e.insn));
                    chk("pop_pc",         64'(bus.pop_pc),         64'(e.pc));
                end
            end
        end
    end

    initial begin
        grp_t g1;
        checks = 0;
        errors = 0;
        mcount = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        drive(1'b0, mk(2'b00, 32'h0), 1'b0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        chk_state("reset");
        chk("reset_slot_valid", 64'(bus.pop_slot_valid), 64'(0));

        // Single group, visible one cycle after the push edge.
        g1.sv   = 2'b11;
        g1.insn = {32'h0010_0093, 32'h0000_0013};
        g1.pc   = {32'h0000_1004, 32'h0000_1000};
        drive(1'b1, g1, 1'b0);
        cycle();
        drive(1'b0, g1, 1'b0);
        chk_state("first");
        chk("first_pop_pc", 64'(bus.pop_pc), {32'h0000_1004, 32'h0000_1000});
        drive(1'b0, g1, 1'b1);
        cycle();
        drive(1'b0, g1, 1'b0);
        chk_state("first_drained");

        // Fill to full, then a held 7th push.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, mk(2'b11, 32'h3000 + 32'(8 * k)), 1'b0);
            cycle();
        end
        chk_state("full");
        drive(1'b1, mk(2'b11, 32'h3030), 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk_state("full_hold");
        end
        drive(1'b1, mk(2'b11, 32'h3030), 1'b1);
        cycle();
        drive(1'b1, mk(2'b11, 32'h3030), 1'b0);
        chk_state("after_pop");
        cycle();
        chk_state("seventh_in");
        drive(1'b0, mk(2'b00, 32'h0), 1'b1);
        repeat (6) cycle();
        drive(1'b0, mk(2'b00, 32'h0), 1'b0);
        chk_state("drained");

        // Streaming push+pop across pointer wrap.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, mk(2'b11, 32'h2000 + 32'(8 * k)), 1'b1);
            cycle();
            chk("stream_count", 64'(bus.count), 64'(1));
        end
        drive(1'b0, mk(2'b00, 32'h0), 1'b1);
        cycle();
        drive(1'b0, mk(2'b00, 32'h0), 1'b0);
        chk_state("stream_done");

        // Flush with concurrent push and pop.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, mk(2'b11, 32'h4000 + 32'(8 * k)), 1'b0);
            cycle();
        end
        drive(1'b1, mk(2'b11, 32'hDEAD_0000), 1'b1);
        flush = 1'b1;
        chk("flush_cycle_pop_valid", 64'(bus.pop_valid), 64'(1));
        cycle();
        flush = 1'b0;
        drive(1'b0, mk(2'b00, 32'h0), 1'b1);
        chk_state("post_flush");
        repeat (3) cycle();
        drive(1'b0, mk(2'b00, 32'h0), 1'b0);

        // Partial group, then empty slot-valid masking.
        drive(1'b1, mk(2'b01, 32'h5000), 1'b0);
        cycle();
        drive(1'b0, mk(2'b00, 32'h0), 1'b0);
        chk("partial_slot_valid", 64'(bus.pop_slot_valid), 64'(2'b01));
        drive(1'b0, mk(2'b00, 32'h0), 1'b1);
        cycle();
        drive(1'b0, mk(2'b00, 32'h0), 1'b0);
        chk("empty_slot_valid", 64'(bus.pop_slot_valid), 64'(2'b00));

        // Reset with traffic active.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk(2'b11, 32'h6000 + 32'(8 * k)), 1'b0);
            cycle();
        end
        chk_state("pre_reset");
        drive(1'b1, mk(2'b11, 32'h6100), 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, mk(2'b00, 32'h0), 1'b0);
        chk_state("mid_reset");
        chk("mid_reset_slot_valid", 64'(bus.pop_slot_valid), 64'(0));
        repeat (2) cycle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_group_queue.md
Name: fetch_group_queue

Overview:
- Decoupling FIFO between the I-cache fetch stage (producer) and the decode stage (consumer).
- Buffers whole fetch groups of FETCH_WIDTH instruction slots. Each slot carries a valid bit, the instruction word and its PC.
- Absorbs decode/rename back-pressure so the fetch stage keeps issuing I-cache accesses.
- Supports a single-cycle flush on branch misprediction or pipeline recovery.

Parameters:
- FETCH_WIDTH, 2, instruction slots per group; equals CONF_FETCH_WIDTH.
- ENTRY_NUM, 6, group entries; need not be a power of two (2..32).
- INSN_BIT_WIDTH, 32, instruction word width.
- PC_BIT_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all stored groups.
- push_valid  in  1  fetch stage presents a group.
- push_ready  out  1  queue accepts a group this cycle.
- push_slot_valid  in  FETCH_WIDTH  per-slot valid.
- push_insn  in  FETCH_WIDTH*INSN_BIT_WIDTH  instructions; slot i in bits [i*W +: W].
- push_pc  in  FETCH_WIDTH*PC_BIT_WIDTH  PCs, packed the same way.
- pop_valid  out  1  head group available.
- pop_ready  in  1  decode consumes the head group.
- pop_slot_valid  out  FETCH_WIDTH  head per-slot valid.
- pop_insn  out  FETCH_WIDTH*INSN_BIT_WIDTH  head instructions.
- pop_pc  out  FETCH_WIDTH*PC_BIT_WIDTH  head PCs.
- count  out  $clog2(ENTRY_NUM+1)  occupied entries.

Behaviour:
- State:
  - head and tail pointers, each $clog2(ENTRY_NUM) bits, wrapping from ENTRY_NUM-1 to 0 by compare-and-clear (no power-of-two masking).
  - count register.
  - storage array; has no reset.
- Reset: rst=1 sets head=0, tail=0, count=0 at the next edge. Consequently pop_valid=0, push_ready=1 and count=0. rst overrides push, pop and flush in the same cycle.
- push_ready = (count != ENTRY_NUM). It is derived from registered state only, with no combinational path from pop_ready. A full queue therefore rejects a push even while a pop is occurring.
- A push fires on push_valid & push_ready & !flush:
  - writes the group at tail;
  - advances tail.
- A push with all push_slot_valid bits 0 is still stored as a group; the producer must not issue one.
- pop_valid = (count != 0). The pop_* data outputs are a combinational read of entry[head]. pop_slot_valid is forced to 0 when pop_valid=0. pop_insn and pop_pc are don't-care when empty.
- A pop fires on pop_valid & pop_ready & !flush and advances head.
- count update: count_next = count + push_fire - pop_fire. Simultaneous push and pop leave count unchanged.
- Latency: a pushed group is visible at pop_* one cycle after the push edge. There is no bypass when empty.
- Flush:
  - flush=1 sets head=0, tail=0, count=0 at the next edge.
  - Same-cycle push and pop are ignored.
  - pop_valid still reflects the pre-flush state during the flush cycle, but no pop fires; decode qualifies with flush.
- Data written by a push is held stable until popped; entries are never overwritten while occupied.
- Assertions (simulation only):
  - push_valid & !push_ready must not be followed by a change of the push data while push_valid stays high (producer holds its request).
  - count never exceeds ENTRY_NUM.

Test Plan:
- Reset, then push 1 group {slot_valid=2'b11, insn={0x00000013, 0x00100093}, pc={0x1000, 0x1004}} with pop_ready=0 → next cycle pop_valid=1, count=1, pop_pc={0x1000, 0x1004}.
- Push 6 groups with pop_ready=0 → count=6 and push_ready=0. A 7th push held for 3 cycles is not accepted and count stays 6. Assert pop_ready for 1 cycle → count=5 and push_ready=1 on the following cycle; the 7th group is accepted only then.
- Continuous push+pop for 20 cycles with sequential PCs 0x2000+8k → popped PCs strictly ascend with no gaps across pointer wrap (5→0) and count holds at 1.
- Queue holding 3 groups; assert flush while also asserting push_valid and pop_ready → next cycle count=0, pop_valid=0, and the flushed-cycle push is never observed at the output.
- Partial group slot_valid=2'b01 pushed → popped with pop_slot_valid=2'b01. Empty queue → pop_slot_valid=2'b00.
- Assert rst while the queue holds 4 groups and push/pop are both active → next cycle count=0, pop_valid=0, push_ready=1.
